pc_peak_detector: RTL and testbench

- Sits directly downstream of the pulse compressor and consumes its 49-bit signed complex output.
- Computes a per-sample magnitude estimate of the compressed I/Q stream using alpha-max-plus-beta-min, with alpha=1 and beta=3/8.
- Tracks the strongest range bin within a fixed-length range window that opens on each tagged pulse-start sample.
- Emits one peak report per completed window (magnitude, bin index, threshold flag) for the downstream detection/display logic.

---
 rtl/pc_peak_detector.sv | 221 ++++++++++++++++++++++
 tb/tb_pc_peak_detector.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_peak_detector.sv
// ---------------------------------------------------------------------------
// pc_peak_detector
//
// Consumes the complex output of the pulse compressor, produces a per-sample
// magnitude estimate (alpha-max-plus-beta-min, alpha = 1, beta = 3/8) and
// tracks the strongest range bin inside a fixed-length window that opens on
// every tagged pulse-start sample. One peak report is emitted per completed
// window.
//
// Ports:
//   clk              system clock
//   rst              synchronous reset, active high
//   data_valid_in    input sample strobe
//   pulse_start_in   marks the current valid sample as bin 0 of a new window
//   i_data_in        signed I sample (DATA_W)
//   q_data_in        signed Q sample (DATA_W)
//   threshold_in     unsigned detection threshold, sampled at report time
//   mag_valid_out    magnitude strobe, 3 cycles after data_valid_in
//   mag_out          unsigned magnitude estimate (MAG_W)
//   peak_valid_out   one-cycle pulse when a window completes
//   peak_mag_out     peak magnitude of the completed window
//   peak_idx_out     bin index of that peak
//   peak_detect_out  peak_mag_out >= threshold_in, qualified by peak_valid_out
//   window_abort_out one-cycle pulse when an open window is restarted
//
// Peak-tracking FSM:
//   state  | meaning
//   IDLE   | no window open; magnitudes stream out but are not tracked
//   ACTIVE | window open; bin_cnt_q is the index of the next untagged sample
// ---------------------------------------------------------------------------
module pc_peak_detector #(
  parameter int DATA_W     = 49,
  parameter int MAG_W      = DATA_W + 1,
  parameter int RANGE_BINS = 1024,
  parameter int IDX_W      = $clog2(RANGE_BINS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     data_valid_in,
  input  logic                     pulse_start_in,
  input  logic signed [DATA_W-1:0] i_data_in,
  input  logic signed [DATA_W-1:0] q_data_in,
  input  logic [MAG_W-1:0]         threshold_in,
  output logic                     mag_valid_out,
  output logic [MAG_W-1:0]         mag_out,
  output logic                     peak_valid_out,
  output logic [MAG_W-1:0]         peak_mag_out,
  output logic [IDX_W-1:0]         peak_idx_out,
  output logic                     peak_detect_out,
  output logic                     window_abort_out
);

  localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(RANGE_BINS - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Absolute value kept as an unsigned DATA_W-bit quantity: the two's
  // complement negation of -2^(DATA_W-1) wraps to exactly 2^(DATA_W-1),
  // which is representable once the result is read as unsigned.
  function automatic logic [DATA_W-1:0] abs_val(input logic signed [DATA_W-1:0] x);
    logic [DATA_W-1:0] ux;
    ux = x;
    return ux[DATA_W-1] ? (~ux + DATA_W'(1)) : ux;
  endfunction

  // ---------------------------------------------------------------------------
  // Magnitude pipeline
  // ---------------------------------------------------------------------------
  logic              s1_valid, s1_tag;
  logic [DATA_W-1:0] s1_a, s1_b;
  logic              s2_valid, s2_tag;
  logic [DATA_W-1:0] s2_mx, s2_mn;
  logic              s3_valid, s3_tag;
  logic [MAG_W-1:0]  s3_mag;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_tag   <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      s1_valid <= data_valid_in;
      s1_tag   <= data_valid_in & pulse_start_in;
      s1_a     <= abs_val(i_data_in);
      s1_b     <= abs_val(q_data_in);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_tag   <= 1'b0;
      s2_mx    <= '0;
      s2_mn    <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_tag   <= s1_tag;
      if (s1_a >= s1_b) begin
        s2_mx <= s1_a;
        s2_mn <= s1_b;
      end else begin
        s2_mx <= s1_b;
        s2_mn <= s1_a;
      end
    end
  end

  // 3/8 * mn approximated as mn/4 + mn/8 with each term truncated; the sum
  // stays below 2^MAG_W for every legal input, so no saturation is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_valid <= 1'b0;
      s3_tag   <= 1'b0;
      s3_mag   <= '0;
    end else begin
      s3_valid <= s2_valid;
      s3_tag   <= s2_tag;
      s3_mag   <= MAG_W'(s2_mx) + MAG_W'(s2_mn >> 2) + MAG_W'(s2_mn >> 3);
    end
  end

  assign mag_valid_out = s3_valid;
  assign mag_out       = s3_mag;

  // ---------------------------------------------------------------------------
  // Peak-tracking FSM
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [IDX_W-1:0] bin_cnt_q, bin_cnt_d;
  logic [MAG_W-1:0] peak_q, peak_d;
  logic [IDX_W-1:0] peak_idx_q, peak_idx_d;
  logic             report_d;
  logic             abort_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bin_cnt_q  <= '0;
      peak_q     <= '0;
      peak_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      bin_cnt_q  <= bin_cnt_d;
      peak_q     <= peak_d;
      peak_idx_q <= peak_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_cnt_d  = bin_cnt_q;
    peak_d     = peak_q;
    peak_idx_d = peak_idx_q;
    report_d   = 1'b0;
    abort_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (s3_valid && s3_tag) begin
          state_d    = ACTIVE;
          bin_cnt_d  = IDX_W'(1);
          peak_d     = s3_mag;
          peak_idx_d = '0;
        end
      end

      ACTIVE: begin
        if (s3_valid) begin
          if (s3_tag) begin
            // A new tag wins even over the old window's final bin.
            abort_d    = 1'b1;
            bin_cnt_d  = IDX_W'(1);
            peak_d     = s3_mag;
            peak_idx_d = '0;
          end else begin
            // Strict compare keeps the earliest bin on ties.
            if (s3_mag > peak_q) begin
              peak_d     = s3_mag;
              peak_idx_d = bin_cnt_q;
            end
            bin_cnt_d = bin_cnt_q + IDX_W'(1);
            if (bin_cnt_q == LAST_BIN) begin
              report_d  = 1'b1;
              state_d   = IDLE;
              bin_cnt_d = '0;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Report registers: the final sample is already folded into peak_d, and the
  // threshold is compared in the same cycle the last magnitude is presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_valid_out   <= 1'b0;
      window_abort_out <= 1'b0;
      peak_mag_out     <= '0;
      peak_idx_out     <= '0;
      peak_detect_out  <= 1'b0;
    end else begin
      peak_valid_out   <= report_d;
      window_abort_out <= abort_d;
      if (report_d) begin
        peak_mag_out    <= peak_d;
        peak_idx_out    <= peak_idx_d;
        peak_detect_out <= (peak_d >= threshold_in);
      end
    end
  end

endmodule

// File: tb/tb_pc_peak_detector.sv
// ---------------------------------------------------------------------------
// tb_pc_peak_detector
//
// Randomized scoreboard bench for pc_peak_detector with a 16-bin window.
// The stimulus side computes expected magnitudes, window reports and abort
// pulses from a list-based window model and queues them with the cycle they
// must appear in; an independent negedge monitor pops and compares whenever
// the DUT raises a strobe.
// ---------------------------------------------------------------------------
module tb_pc_peak_detector;

  localparam int DATA_W     = 49;
  localparam int MAG_W      = 50;
  localparam int RANGE_BINS = 16;
  localparam int IDX_W      = 4;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     data_valid_in = 1'b0;
  logic                     pulse_start_in = 1'b0;
  logic signed [DATA_W-1:0] i_data_in = '0;
  logic signed [DATA_W-1:0] q_data_in = '0;
  logic [MAG_W-1:0]         threshold_in = '0;
  logic                     mag_valid_out;
  logic [MAG_W-1:0]         mag_out;
  logic                     peak_valid_out;
  logic [MAG_W-1:0]         peak_mag_out;
  logic [IDX_W-1:0]         peak_idx_out;
  logic                     peak_detect_out;
  logic                     window_abort_out;

  pc_peak_detector #(
    .DATA_W     (DATA_W),
    .MAG_W      (MAG_W),
    .RANGE_BINS (RANGE_BINS),
    .IDX_W      (IDX_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .data_valid_in    (data_valid_in),
    .pulse_start_in   (pulse_start_in),
    .i_data_in        (i_data_in),
    .q_data_in        (q_data_in),
    .threshold_in     (threshold_in),
    .mag_valid_out    (mag_valid_out),
    .mag_out          (mag_out),
    .peak_valid_out   (peak_valid_out),
    .peak_mag_out     (peak_mag_out),
    .peak_idx_out     (peak_idx_out),
    .peak_detect_out  (peak_detect_out),
    .window_abort_out (window_abort_out)
  );

  always #5 clk = ~clk;

  int   cycle = 0;
  logic rst_q = 1'b1;
  always @(posedge clk) begin
    cycle = cycle + 1;
    rst_q = rst;
  end

  typedef struct {
    logic [MAG_W-1:0] mag;
    int               stamp;
  } mag_exp_t;

  typedef struct {
    logic [MAG_W-1:0] mag;
    logic [IDX_W-1:0] idx;
    logic             det;
    int               stamp;
  } rep_exp_t;

  mag_exp_t         mag_q[$];
  rep_exp_t         rep_q[$];
  int               abort_q[$];
  logic [MAG_W-1:0] win[$];
  bit               win_open = 1'b0;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic unexpected(input string name);
    checks = checks + 1;
    errors = errors + 1;
    $display("FAIL %s: strobe seen with nothing expected (cycle %0d)", name, cycle);
  endtask

  // Reference magnitude straight from the formula: max + floor(3/8-ish) terms.
  function automatic logic [MAG_W-1:0] ref_mag(input logic signed [DATA_W-1:0] i,
                                               input logic signed [DATA_W-1:0] q);
    longint ii, qq, a, b, mx, mn;
    ii = i;
    qq = q;
    a  = (ii < 0) ? -ii : ii;
    b  = (qq < 0) ? -qq : qq;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    return MAG_W'(mx + mn / 4 + mn / 8);
  endfunction

  task automatic model_issue(input logic signed [DATA_W-1:0] i,
                             input logic signed [DATA_W-1:0] q,
                             input bit tag, input int stamp);
    logic [MAG_W-1:0] m;
    logic [MAG_W-1:0] pk;
    int               pk_idx;
    m = ref_mag(i, q);
    mag_q.push_back('{m, stamp + 3});
    if (tag) begin
      if (win_open) abort_q.push_back(stamp + 4);
      win.delete();
      win.push_back(m);
      win_open = 1'b1;
    end else if (win_open) begin
      win.push_back(m);
      if (win.size() == RANGE_BINS) begin
        pk     = win[0];
        pk_idx = 0;
        foreach (win[k]) begin
          if (win[k] > pk) begin
            pk     = win[k];
            pk_idx = k;
          end
        end
        rep_q.push_back('{pk, IDX_W'(pk_idx), (pk >= threshold_in), stamp + 4});
        win_open = 1'b0;
        win.delete();
      end
    end
  endtask

  // Drives are applied 1 ns after the rising edge; the monitor samples on
  // the falling edge, so both see the same value of cycle.
  task automatic drive(input bit v, input logic signed [DATA_W-1:0] i,
                       input logic signed [DATA_W-1:0] q, input bit tag);
    @(posedge clk);
    #1;
    data_valid_in  = v;
    i_data_in      = i;
    q_data_in      = q;
    pulse_start_in = tag;
    if (v) model_issue(i, q, tag, cycle);
  endtask

  function automatic logic signed [DATA_W-1:0] rnd_full();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[DATA_W-1:0];
  endfunction

  function automatic logic signed [DATA_W-1:0] rnd_small();
    logic signed [DATA_W-1:0] x;
    x = DATA_W'($urandom_range(0, 1 << 20));
    if ($urandom_range(0, 1) == 1) x = -x;
    return x;
  endfunction

  // Pure real magnitude with random sign on I; mag equals v exactly.
  function automatic logic signed [DATA_W-1:0] signed_val(input int v);
    logic signed [DATA_W-1:0] x;
    x = DATA_W'(v);
    if ($urandom_range(0, 1) == 1) x = -x;
    return x;
  endfunction

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, rnd_full(), rnd_full(), 1'($urandom_range(0, 1)));
  endtask

  task automatic gaps(input int max_gap);
    idle($urandom_range(0, max_gap));
  endtask

  // Holds rst for n cycles (n >= 2) while valid samples keep streaming. The
  // queues are flushed once the last pre-reset output has been checked.
  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst            = 1'b1;
    data_valid_in  = 1'b1;
    pulse_start_in = 1'b1;
    i_data_in      = rnd_full();
    q_data_in      = rnd_full();
    for (int k = 1; k < n; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        mag_q.delete();
        rep_q.delete();
        abort_q.delete();
        win.delete();
        win_open = 1'b0;
      end
      data_valid_in  = 1'b1;
      pulse_start_in = 1'($urandom_range(0, 1));
      i_data_in      = rnd_full();
      q_data_in      = rnd_full();
    end
    @(posedge clk);
    #1;
    rst            = 1'b0;
    data_valid_in  = 1'b0;
    pulse_start_in = 1'b0;
  endtask

  task automatic ramp_window(input int spike_bin, input int spike_val);
    for (int b = 0; b < RANGE_BINS; b++)
      drive(1'b1, signed_val((b == spike_bin) ? spike_val : b), '0, (b == 0));
  endtask

  task automatic rand_window(input int restart_pct, input int max_gap);
    drive(1'b1, rnd_small(), rnd_small(), 1'b1);
    for (int b = 1; b < RANGE_BINS; b++) begin
      gaps(max_gap);
      drive(1'b1, rnd_small(), rnd_small(), ($urandom_range(0, 99) < restart_pct));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    mag_exp_t me;
    rep_exp_t re;
    int       ae;
    if (rst_q) begin
      check("reset_strobes", 64'({mag_valid_out, peak_valid_out, window_abort_out, peak_detect_out}), 64'd0);
      check("reset_values", 64'({|mag_out, |peak_mag_out, |peak_idx_out}), 64'd0);
    end else begin
      if (mag_valid_out) begin
        if (mag_q.size() == 0) unexpected("mag_valid");
        else begin
          me = mag_q.pop_front();
          check("mag_value", 64'(mag_out), 64'(me.mag));
          check("mag_latency", 64'(cycle), 64'(me.stamp));
        end
      end
      if (peak_valid_out) begin
        if (rep_q.size() == 0) unexpected("peak_valid");
        else begin
          re = rep_q.pop_front();
          check("peak_mag", 64'(peak_mag_out), 64'(re.mag));
          check("peak_idx", 64'(peak_idx_out), 64'(re.idx));
          check("peak_detect", 64'(peak_detect_out), 64'(re.det));
          check("peak_latency", 64'(cycle), 64'(re.stamp));
        end
      end
      if (window_abort_out) begin
        if (abort_q.size() == 0) unexpected("window_abort");
        else begin
          ae = abort_q.pop_front();
          check("abort_latency", 64'(cycle), 64'(ae));
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cycle);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic signed [DATA_W-1:0] neg_full;
    logic signed [DATA_W-1:0] pos_max;
    neg_full = 49'sh1000000000000;
    pos_max  = 49'sh0FFFFFFFFFFFF;

    do_reset(3);

    // magnitude corner cases, no window open
    drive(1'b1, neg_full, '0, 1'b0);
    drive(1'b1, DATA_W'(800), -DATA_W'(400), 1'b0);
    drive(1'b1, pos_max, pos_max, 1'b0);
    drive(1'b1, '0, neg_full, 1'b0);
    drive(1'b1, neg_full, neg_full, 1'b0);
    for (int k = 0; k < 8; k++) drive(1'b1, rnd_full(), rnd_full(), 1'b0);
    idle(5);

    // spike at bin 9, threshold exactly at and just above the peak
    threshold_in = MAG_W'(10000);
    ramp_window(9, 10000);
    idle(6);
    threshold_in = MAG_W'(10001);
    ramp_window(9, 10000);
    idle(6);

    // equal maxima at bins 3 and 7 with random valid gaps
    threshold_in = MAG_W'(9000);
    for (int b = 0; b < RANGE_BINS; b++) begin
      gaps(3);
      drive(1'b1, signed_val((b == 3 || b == 7) ? 9000 : int'($urandom_range(0, 8999))), '0, (b == 0));
    end
    idle(6);

    // restart at bin 15 of an open window, then back-to-back windows
    threshold_in = MAG_W'(500);
    for (int b = 0; b < RANGE_BINS; b++)
      drive(1'b1, signed_val(int'($urandom_range(0, 1000))), '0, (b == 0 || b == RANGE_BINS - 1));
    for (int b = 1; b < RANGE_BINS; b++)
      drive(1'b1, signed_val(int'($urandom_range(0, 1000))), '0, 1'b0);
    ramp_window(5, 700);
    ramp_window(12, 300);
    idle(6);

    // random windows with gaps and occasional restarts
    for (int w = 0; w < 8; w++) begin
      threshold_in = MAG_W'($urandom_range(0, 1 << 21));
      rand_window((w % 2 == 0) ? 0 : 8, 2);
      idle(5);
    end

    // reset in the middle of a window, then a clean window
    threshold_in = MAG_W'(12);
    for (int b = 0; b < 8; b++) drive(1'b1, signed_val(b * 3), '0, (b == 0));
    do_reset(3);
    idle(2);
    ramp_window(14, 20);
    idle(8);

    check("mag_queue_drained", 64'(mag_q.size()), 64'd0);
    check("report_queue_drained", 64'(rep_q.size()), 64'd0);
    check("abort_queue_drained", 64'(abort_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
